// File: rtl/pong_score_if.sv
// Score/overlay bus for pong_score_overlay: hit events, scan coordinate in; scores, digit patterns, pixel hits out.
interface pong_score_if;
  logic       right_hit;
  logic       left_hit;
  logic       clear;
  logic [9:0] x;
  logic [9:0] y;
  logic [4:0] score_p1;
  logic [4:0] score_p2;
  logic [6:0] seg_p1_tens;
  logic [6:0] seg_p1_ones;
  logic [6:0] seg_p2_tens;
  logic [6:0] seg_p2_ones;
  logic [3:0] digit_pixel;
  logic       pixel_on;

  modport master (
    output right_hit, left_hit, clear, x, y,
    input  score_p1, score_p2, seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones,
           digit_pixel, pixel_on
  );

  modport slave (
    input  right_hit, left_hit, clear, x, y,
    output score_p1, score_p2, seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones,
           digit_pixel, pixel_on
  );
endinterface

// File: rtl/pong_score_overlay.sv
// Pong score keeper: per-player saturating scores, 7-segment decode and per-pixel digit overlay.
// Optional macro SCORE_BLANK_LEADING_ZERO_EN blanks the tens digit while a score is below 10.
module pong_score_overlay #(
  parameter int unsigned MAX_SCORE = 31,
  parameter int unsigned P1_TENS_X = 242,
  parameter int unsigned P1_ONES_X = 276,
  parameter int unsigned P2_TENS_X = 340,
  parameter int unsigned P2_ONES_X = 374,
  parameter int unsigned DIGIT_Y   = 25,
  parameter int unsigned DIGIT_W   = 24,
  parameter int unsigned DIGIT_H   = 44,
  parameter int unsigned SEG_T     = 4
) (
  input logic         clk,
  input logic         reset,
  pong_score_if.slave bus
);

  localparam int unsigned SCORE_W = 5;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned MID     = DIGIT_H / 2 - SEG_T / 2;

  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);

  localparam logic [COORD_W-1:0] W10 = COORD_W'(DIGIT_W);
  localparam logic [COORD_W-1:0] T10 = COORD_W'(SEG_T);
  localparam logic [COORD_W-1:0] YA0 = COORD_W'(DIGIT_Y);
  localparam logic [COORD_W-1:0] YA1 = COORD_W'(DIGIT_Y + SEG_T);
  localparam logic [COORD_W-1:0] YM0 = COORD_W'(DIGIT_Y + MID);
  localparam logic [COORD_W-1:0] YM1 = COORD_W'(DIGIT_Y + MID + SEG_T);
  localparam logic [COORD_W-1:0] YD0 = COORD_W'(DIGIT_Y + DIGIT_H - SEG_T);
  localparam logic [COORD_W-1:0] YD1 = COORD_W'(DIGIT_Y + DIGIT_H);

  localparam logic [COORD_W-1:0] X_P1T = COORD_W'(P1_TENS_X);
  localparam logic [COORD_W-1:0] X_P1O = COORD_W'(P1_ONES_X);
  localparam logic [COORD_W-1:0] X_P2T = COORD_W'(P2_TENS_X);
  localparam logic [COORD_W-1:0] X_P2O = COORD_W'(P2_ONES_X);

  logic               right_q, left_q;
  logic [SCORE_W-1:0] score_p1_q, score_p2_q;
  logic [3:0]         digit_pixel_q;
  logic               pixel_on_q;

  logic               right_edge_c, left_edge_c;
  logic [6:0]         p1_tens_c, p1_ones_c, p2_tens_c, p2_ones_c;
  logic [3:0]         digit_pixel_c;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] tens_pattern(input logic [SCORE_W-1:0] s);
    logic [6:0] p;
    p = seg7(4'(s / SCORE_W'(10)));
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    if (s < SCORE_W'(10)) p = 7'h00;
`endif
    return p;
  endfunction

  function automatic logic [6:0] ones_pattern(input logic [SCORE_W-1:0] s);
    return seg7(4'(s % SCORE_W'(10)));
  endfunction

  // Column bands (full width, left bar, right bar) crossed with row bands select each segment.
  function automatic logic digit_hit(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                     input logic [COORD_W-1:0] x0, input logic [6:0] seg);
    logic col_full, col_left, col_right;
    logic row_a, row_g, row_d, row_up, row_lo;
    col_full  = (px >= x0) && (px < x0 + W10);
    col_left  = (px >= x0) && (px < x0 + T10);
    col_right = (px >= x0 + W10 - T10) && (px < x0 + W10);
    row_a     = (py >= YA0) && (py < YA1);
    row_g     = (py >= YM0) && (py < YM1);
    row_d     = (py >= YD0) && (py < YD1);
    row_up    = (py >= YA0) && (py < YM1);
    row_lo    = (py >= YM0) && (py < YD1);
    return (seg[0] & col_full  & row_a)  |
           (seg[1] & col_right & row_up) |
           (seg[2] & col_right & row_lo) |
           (seg[3] & col_full  & row_d)  |
           (seg[4] & col_left  & row_lo) |
           (seg[5] & col_left  & row_up) |
           (seg[6] & col_full  & row_g);
  endfunction

  always_comb begin
    right_edge_c  = bus.right_hit & ~right_q;
    left_edge_c   = bus.left_hit  & ~left_q;
    p1_tens_c     = tens_pattern(score_p1_q);
    p1_ones_c     = ones_pattern(score_p1_q);
    p2_tens_c     = tens_pattern(score_p2_q);
    p2_ones_c     = ones_pattern(score_p2_q);
    digit_pixel_c = {digit_hit(bus.x, bus.y, X_P2O, p2_ones_c),
                     digit_hit(bus.x, bus.y, X_P2T, p2_tens_c),
                     digit_hit(bus.x, bus.y, X_P1O, p1_ones_c),
                     digit_hit(bus.x, bus.y, X_P1T, p1_tens_c)};
  end

  // Edge registers reset high so a hit already asserted at reset release is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      right_q    <= 1'b1;
      left_q     <= 1'b1;
      score_p1_q <= '0;
      score_p2_q <= '0;
    end else begin
      right_q <= bus.right_hit;
      left_q  <= bus.left_hit;
      if (bus.clear) begin
        score_p1_q <= '0;
        score_p2_q <= '0;
      end else begin
        if (right_edge_c && (score_p1_q < MAX_S)) score_p1_q <= score_p1_q + SCORE_W'(1);
        if (left_edge_c  && (score_p2_q < MAX_S)) score_p2_q <= score_p2_q + SCORE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_pixel_q <= '0;
      pixel_on_q    <= 1'b0;
    end else begin
      digit_pixel_q <= digit_pixel_c;
      pixel_on_q    <= |digit_pixel_c;
    end
  end

  assign bus.score_p1    = score_p1_q;
  assign bus.score_p2    = score_p2_q;
  assign bus.seg_p1_tens = p1_tens_c;
  assign bus.seg_p1_ones = p1_ones_c;
  assign bus.seg_p2_tens = p2_tens_c;
  assign bus.seg_p2_ones = p2_ones_c;
  assign bus.digit_pixel = digit_pixel_q;
  assign bus.pixel_on    = pixel_on_q;

endmodule

// File: tb/tb_pong_score_overlay.sv
// Testbench for pong_score_overlay: directed scenarios plus randomized traffic against a behavioural score/pixel model.
module tb_pong_score_overlay;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pong_score_if bus ();

  pong_score_overlay dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: scores as plain integers, last sampled hit levels, expected pixel register.
  int         m_p1, m_p2;
  bit         m_prev_r, m_prev_l;
  logic [3:0] m_pix;
  logic [6:0] pat [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         xs [0:3] = '{242, 276, 340, 374};

  function automatic logic [6:0] ref_tens(input int s);
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    if (s < 10) return 7'h00;
`endif
    return pat[s / 10];
  endfunction

  function automatic logic [6:0] ref_ones(input int s);
    return pat[s % 10];
  endfunction

  // Geometry from the segment rectangles in digit-relative coordinates (W=24, H=44, T=4, M=20).
  function automatic bit ref_lit(input int px, input int py, input int x0, input logic [6:0] p);
    int dx, dy;
    bit r;
    dx = px - x0;
    dy = py - 25;
    if (dx < 0 || dx >= 24 || dy < 0 || dy >= 44) return 1'b0;
    r = 1'b0;
    if (p[0] && dy < 4)                  r = 1'b1;
    if (p[6] && dy >= 20 && dy < 24)     r = 1'b1;
    if (p[3] && dy >= 40)                r = 1'b1;
    if (p[5] && dx < 4 && dy < 24)       r = 1'b1;
    if (p[1] && dx >= 20 && dy < 24)     r = 1'b1;
    if (p[4] && dx < 4 && dy >= 20)      r = 1'b1;
    if (p[2] && dx >= 20 && dy >= 20)    r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_prev_r = 1'b1; m_prev_l = 1'b1; m_pix = 4'b0000;
  endtask

  // One clock: predict the registered outputs from pre-edge state, then advance past the edge.
  task automatic step();
    int  px, py;
    bit  er, el;
    px = int'(bus.x);
    py = int'(bus.y);
    m_pix = {ref_lit(px, py, xs[3], ref_ones(m_p2)), ref_lit(px, py, xs[2], ref_tens(m_p2)),
             ref_lit(px, py, xs[1], ref_ones(m_p1)), ref_lit(px, py, xs[0], ref_tens(m_p1))};
    er = bus.right_hit && !m_prev_r;
    el = bus.left_hit  && !m_prev_l;
    m_prev_r = bus.right_hit;
    m_prev_l = bus.left_hit;
    if (bus.clear) begin
      m_p1 = 0; m_p2 = 0;
    end else begin
      if (er && m_p1 < 31) m_p1++;
      if (el && m_p2 < 31) m_p2++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".score_p1"},    32'(bus.score_p1),    32'(m_p1));
    chk({tag, ".score_p2"},    32'(bus.score_p2),    32'(m_p2));
    chk({tag, ".seg_p1_tens"}, 32'(bus.seg_p1_tens), 32'(ref_tens(m_p1)));
    chk({tag, ".seg_p1_ones"}, 32'(bus.seg_p1_ones), 32'(ref_ones(m_p1)));
    chk({tag, ".seg_p2_tens"}, 32'(bus.seg_p2_tens), 32'(ref_tens(m_p2)));
    chk({tag, ".seg_p2_ones"}, 32'(bus.seg_p2_ones), 32'(ref_ones(m_p2)));
    chk({tag, ".digit_pixel"}, 32'(bus.digit_pixel), 32'(m_pix));
    chk({tag, ".pixel_on"},    32'(bus.pixel_on),    32'(|m_pix));
  endtask

  task automatic pulse_right();
    bus.right_hit = 1'b1; step();
    bus.right_hit = 1'b0; step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.right_hit = 1'b1;
    bus.left_hit  = 1'b0;
    bus.clear     = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    model_reset();

    // Reset state, then release with right_hit already high: not counted.
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset");
    reset = 1'b1;
    step();
    chk("held_at_release", 32'(bus.score_p1), 32'd0);
    bus.right_hit = 1'b0; step();
    bus.right_hit = 1'b1; step();
    chk("first_hit.score_p1", 32'(bus.score_p1), 32'd1);
    chk("first_hit.seg_p1_ones", 32'(bus.seg_p1_ones), 32'h06);
    bus.right_hit = 1'b0; step();

    // Twelve left pulses, then a long right level counts once.
    for (int i = 0; i < 12; i++) begin
      bus.left_hit = 1'b1; step();
      bus.left_hit = 1'b0; step();
    end
    chk("p2_twelve.score", 32'(bus.score_p2), 32'd12);
    chk("p2_twelve.tens", 32'(bus.seg_p2_tens), 32'h06);
    chk("p2_twelve.ones", 32'(bus.seg_p2_ones), 32'h5B);
    bus.right_hit = 1'b1;
    repeat (5) step();
    bus.right_hit = 1'b0; step();
    chk("level_once.score_p1", 32'(bus.score_p1), 32'd2);

    // Pixel geometry at score 0.
    bus.clear = 1'b1; step();
    bus.clear = 1'b0;
    chk_all("clear");
    bus.x = 10'd242; bus.y = 10'd25; step();
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    chk("corner_p1_tens", 32'(bus.digit_pixel), 32'b0000);
`else
    chk("corner_p1_tens", 32'(bus.digit_pixel), 32'b0001);
`endif
    chk_all("corner");
    bus.x = 10'd252; bus.y = 10'd35; step();
    chk("zero_hole", 32'(bus.digit_pixel), 32'b0000);
    bus.x = 10'd0; bus.y = 10'd0; step();
    chk("origin.pixel_on", 32'(bus.pixel_on), 32'd0);
    bus.x = 10'd276; bus.y = 10'd68; step();
    chk("p1_ones_bottom_row", 32'(bus.digit_pixel), 32'b0010);
    bus.x = 10'd276; bus.y = 10'd69; step();
    chk("below_digit", 32'(bus.digit_pixel), 32'b0000);

    // Saturation at 31.
    for (int i = 0; i < 33; i++) pulse_right();
    chk("sat.score_p1", 32'(bus.score_p1), 32'd31);
    chk("sat.tens", 32'(bus.seg_p1_tens), 32'h4F);
    chk("sat.ones", 32'(bus.seg_p1_ones), 32'h06);
    pulse_right();
    chk("sat_again.score_p1", 32'(bus.score_p1), 32'd31);

    // Clear wins over simultaneous edges; both edges without clear both count.
    bus.right_hit = 1'b1; bus.left_hit = 1'b1; bus.clear = 1'b1; step();
    bus.clear = 1'b0;
    chk("clear_prio.p1", 32'(bus.score_p1), 32'd0);
    chk("clear_prio.p2", 32'(bus.score_p2), 32'd0);
    bus.right_hit = 1'b0; bus.left_hit = 1'b0; step();
    bus.right_hit = 1'b1; bus.left_hit = 1'b1; step();
    chk("both.p1", 32'(bus.score_p1), 32'd1);
    chk("both.p2", 32'(bus.score_p2), 32'd1);
    bus.right_hit = 1'b0; bus.left_hit = 1'b0; step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.right_hit = ($urandom_range(0, 2) == 0);
      bus.left_hit  = ($urandom_range(0, 2) == 0);
      bus.clear     = ($urandom_range(0, 60) == 0);
      bus.x         = 10'($urandom_range(230, 410));
      bus.y         = 10'($urandom_range(18, 75));
      step();
      chk_all("rand");
    end

    // Asynchronous reset mid-count with a lit pixel.
    bus.right_hit = 1'b0; bus.left_hit = 1'b0; bus.clear = 1'b1; step();
    bus.clear = 1'b0;
    for (int i = 0; i < 7; i++) pulse_right();
    bus.x = 10'd280; bus.y = 10'd26; step();
    chk("pre_reset.score_p1", 32'(bus.score_p1), 32'd7);
    chk("pre_reset.pixel_on", 32'(bus.pixel_on), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async.score_p1", 32'(bus.score_p1), 32'd0);
    chk("async.pixel_on", 32'(bus.pixel_on), 32'd0);
    chk("async.digit_pixel", 32'(bus.digit_pixel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
